i2c_slave_xfer_ctrl: RTL
========================

// Module: i2c_slave_xfer_ctrl
// PURPOSE
//  Byte/ACK sequencer for the I2C slave. Consumes the SCL edge and START/STOP strobes from the bus detectors.
//  Drives an internal 4-bit flex_counter (clear/count_enable/rollover_val=8) as the bit counter.
//  Shifts SDA in and out, and decides ACK/NACK. Sits between the bus-edge logic and the byte FIFOs.
// PARAMETERS
//  SLAVE_ADDR   7'h1A  7-bit address this slave ACKs
//  BIT_CNT_BITS 4      width of the bit counter; must hold the value 8
// PORTS
//  clk               in   1  system clock
//  n_rst             in   1  async reset, active low
//  start_found       in   1  1-cycle pulse: START or repeated START detected
//  stop_found        in   1  1-cycle pulse: STOP detected
//  rising_edge_scl   in   1  1-cycle pulse: SCL rose (sample point)
//  falling_edge_scl  in   1  1-cycle pulse: SCL fell (drive point)
//  sda_in            in   1  synchronized SDA
//  tx_data           in   8  next byte to transmit (read transfers)
//  sda_out           out  1  value driven when sda_out_en=1
//  sda_out_en        out  1  1 = pull SDA to sda_out; 0 = release
//  rx_data           out  8  last received data byte
//  rx_valid          out  1  1-cycle pulse: rx_data updated
//  tx_load           out  1  1-cycle pulse: tx_data consumed, present next byte
//  rw_mode           out  1  R/W bit of the matched address byte (1=read)
//  busy              out  1  1 in any state other than IDLE
//  general_call      out  1  matched address 7'h00 (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; bit counter=0; all outputs 0 (sda_out_en=0 releases bus).
//  All outputs are registered; each reacts 1 clk after the triggering strobe.
//  Bit counter:
//   - count_enable = rising_edge_scl in ADDR/RX_BYTE/TX_BYTE.
//   - clear on START, or on the transition into ADDR/RX_BYTE/TX_BYTE.
//   - Counts 1..8. Byte complete = rollover_flag (count==8).
//  States/transitions (stop_found beats start_found beats edges, from any state):
//   IDLE     : start_found -> ADDR.
//   ADDR     : shift sda_in MSB-first on rising edges. Byte complete + falling edge:
//              addr[7:1]==SLAVE_ADDR -> ADDR_ACK, rw_mode=addr[0]; else -> WAIT_STOP (NACK).
//   ADDR_ACK : sda_out_en=1, sda_out=0. Next falling edge: rw_mode=0 -> RX_BYTE; rw_mode=1 -> TX_BYTE.
//   RX_BYTE  : shift sda_in, SDA released. Byte complete -> rx_data updated, rx_valid pulses once.
//              Next falling edge -> RX_ACK.
//   RX_ACK   : drive 0 for one SCL period. Next falling edge -> RX_BYTE.
//   TX_BYTE  : on entry, capture tx_data into shift reg, pulse tx_load next cycle, drive MSB.
//              Shift left on each falling edge while count<8. Byte complete + falling edge -> TX_ACK.
//   TX_ACK   : release SDA; sample sda_in on rising edge.
//              0 (ACK) -> TX_BYTE on next falling edge; 1 (NACK) -> WAIT_STOP.
//   WAIT_STOP: SDA released, ignore edges until stop_found (IDLE) or start_found (ADDR).
//  Boundaries:
//   - stop_found mid-byte: partial byte discarded, no rx_valid, -> IDLE.
//   - Repeated START mid-byte: counter cleared, -> ADDR, rw_mode held until next address match.
//   - rising and falling strobes in the same cycle: protocol violation, rising processed, falling ignored.
//   - n_rst mid-transfer: immediate release of SDA, state IDLE.
// CONFIGURATION
//  I2C_GENERAL_CALL_EN defined:
//   - address byte 8'h00 also matches -> ADDR_ACK, rw_mode=0, general_call=1.
//   - general_call holds until STOP or START.
//  I2C_GENERAL_CALL_EN undefined:
//   - 8'h00 is NACKed like any mismatch.
//   - general_call is tied 0.
// TESTING
//  1 Write 0x34 (addr 0x1A,W) + data 0xA5 -> ACK both bytes; rx_data=0xA5; exactly one rx_valid; busy until STOP.
//  2 Address 0x2B,W -> no SDA drive at 9th bit; WAIT_STOP; rx_valid never pulses.
//  3 Read 0x35, tx_data=0xC3 then 0x5A, master ACK then NACK -> SDA bits 11000011,01011010; two tx_load; WAIT_STOP.
//  4 STOP after 4 data bits -> IDLE next cycle, sda_out_en=0, rx_data unchanged.
//  5 Repeated START during RX_BYTE then addr 0x35 -> counter restarts at 0, ACK, rw_mode=1.
//  6 Address 0x00: with I2C_GENERAL_CALL_EN -> ACK, general_call=1; without it -> NACK, general_call=0.

Source files
------------

// File: rtl/i2c_slave_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_xfer_ctrl
// Description : Byte/ACK sequencer for an I2C slave. Takes SCL edge strobes
//               and START/STOP strobes from the bus detectors. Uses a 4-bit
//               bit counter (clear / count enable / rollover at 8). Shifts SDA
//               in and out, and decides ACK/NACK.
//               Optional feature macro: I2C_GENERAL_CALL_EN. When it is
//               defined, address byte 8'h00 is also ACKed and general_call is
//               flagged.
// Ports       :
//   clk              in   system clock
//   n_rst            in   asynchronous reset, active low
//   start_found      in   1-cycle pulse, START / repeated START seen
//   stop_found       in   1-cycle pulse, STOP seen
//   rising_edge_scl  in   1-cycle pulse, SCL rose (sample point)
//   falling_edge_scl in   1-cycle pulse, SCL fell (drive point)
//   sda_in           in   synchronized SDA
//   tx_data[7:0]     in   next byte to transmit on reads
//   sda_out          out  level driven while sda_out_en=1
//   sda_out_en       out  1 = drive SDA, 0 = release
//   rx_data[7:0]     out  last received data byte
//   rx_valid         out  1-cycle pulse, rx_data updated
//   tx_load          out  1-cycle pulse, tx_data consumed
//   rw_mode          out  R/W bit of last matched address (1 = read)
//   busy             out  controller not in IDLE
//   general_call     out  general-call address matched
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_xfer_ctrl #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h1A,
    parameter int         BIT_CNT_BITS = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge_scl,
    input  logic       falling_edge_scl,
    input  logic       sda_in,
    input  logic [7:0] tx_data,
    output logic       sda_out,
    output logic       sda_out_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       rw_mode,
    output logic       busy,
    output logic       general_call
);

    localparam logic [BIT_CNT_BITS-1:0] CNT_ROLLOVER = BIT_CNT_BITS'(8);
    localparam logic [BIT_CNT_BITS-1:0] CNT_LAST     = BIT_CNT_BITS'(7);
    localparam logic [BIT_CNT_BITS-1:0] CNT_ONE      = BIT_CNT_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX_BYTE   = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX_BYTE   = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [BIT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]              rx_shift_q, rx_shift_d;
    logic [7:0]              tx_shift_q, tx_shift_d;
    logic [7:0]              rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    tx_load_q, tx_load_d;
    logic                    rw_mode_q, rw_mode_d;
    logic                    gcall_q, gcall_d;
    logic                    mack_q, mack_d;
    logic                    sda_out_q, sda_out_d;
    logic                    sda_out_en_q, sda_out_en_d;
    logic                    busy_q, busy_d;

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_byte_done;
    logic                    w_gc_match;
    logic                    w_cnt_state;
    logic                    w_cnt_clr;
    logic                    w_cnt_en;

    // A simultaneous rise/fall is a protocol violation: only the rise counts.
    assign w_rise      = rising_edge_scl;
    assign w_fall      = falling_edge_scl & ~rising_edge_scl;
    assign w_byte_done = (cnt_q == CNT_ROLLOVER);

`ifdef I2C_GENERAL_CALL_EN
    assign w_gc_match = (rx_shift_q == 8'h00);
`else
    assign w_gc_match = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bit counter: counts rising SCL edges within a byte, 1..8
    // ------------------------------------------------------------------
    assign w_cnt_state = (state_q == S_ADDR) || (state_q == S_RX_BYTE) ||
                         (state_q == S_TX_BYTE);
    assign w_cnt_clr   = start_found ||
                         ((state_d != state_q) &&
                          ((state_d == S_ADDR) || (state_d == S_RX_BYTE) ||
                           (state_d == S_TX_BYTE)));
    assign w_cnt_en    = w_rise && w_cnt_state && !stop_found;

    always_comb begin
        cnt_d = cnt_q;
        if (w_cnt_clr) begin
            cnt_d = '0;
        end else if (w_cnt_en) begin
            cnt_d = (cnt_q == CNT_ROLLOVER) ? CNT_ONE : (cnt_q + CNT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        rw_mode_d  = rw_mode_q;
        gcall_d    = gcall_q;
        mack_d     = mack_q;

        if (stop_found) begin
            state_d = S_IDLE;
            gcall_d = 1'b0;
        end else if (start_found) begin
            state_d = S_ADDR;
            gcall_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], sda_in};
                    end else if (w_fall && w_byte_done) begin
                        if (rx_shift_q[7:1] == SLAVE_ADDR) begin
                            state_d   = S_ADDR_ACK;
                            rw_mode_d = rx_shift_q[0];
                        end else if (w_gc_match) begin
                            state_d   = S_ADDR_ACK;
                            rw_mode_d = 1'b0;
                            gcall_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_fall) begin
                        if (rw_mode_q) begin
                            state_d    = S_TX_BYTE;
                            tx_shift_d = tx_data;
                            tx_load_d  = 1'b1;
                        end else begin
                            state_d = S_RX_BYTE;
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (w_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], sda_in};
                        // Eighth bit arriving: publish the completed byte.
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = {rx_shift_q[6:0], sda_in};
                            rx_valid_d = 1'b1;
                        end
                    end else if (w_fall && w_byte_done) begin
                        state_d = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (w_fall) begin
                        state_d = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (w_fall) begin
                        if (w_byte_done) begin
                            state_d = S_TX_ACK;
                            mack_d  = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_rise) begin
                        // Master NACK ends the read; ACK waits for SCL low.
                        if (sda_in) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (w_fall && mack_q) begin
                        state_d    = S_TX_BYTE;
                        tx_shift_d = tx_data;
                        tx_load_d  = 1'b1;
                    end
                end
                S_WAIT_STOP: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // SDA drive follows the state being entered so it changes one clock
        // after the strobe that caused the transition.
        sda_out_en_d = (state_d == S_ADDR_ACK) || (state_d == S_RX_ACK) ||
                       (state_d == S_TX_BYTE);
        sda_out_d    = (state_d == S_TX_BYTE) ? tx_shift_d[7] : 1'b0;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            rw_mode_q    <= 1'b0;
            gcall_q      <= 1'b0;
            mack_q       <= 1'b0;
            sda_out_q    <= 1'b0;
            sda_out_en_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_load_q    <= tx_load_d;
            rw_mode_q    <= rw_mode_d;
            gcall_q      <= gcall_d;
            mack_q       <= mack_d;
            sda_out_q    <= sda_out_d;
            sda_out_en_q <= sda_out_en_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_out      = sda_out_q;
    assign sda_out_en   = sda_out_en_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_load      = tx_load_q;
    assign rw_mode      = rw_mode_q;
    assign busy         = busy_q;
    assign general_call = gcall_q;

endmodule
`default_nettype wire
